uart_byte_bridge: RTL and testbench
===================================

UART_BYTE_BRIDGE -- requirements
Module: uart_byte_bridge

Interface
REQ-001 Parameter DEPTH, default 8, SHALL set FIFO depth in bytes; legal values are powers of 2 from 2 to 64.
REQ-002 Parameter BUSY_TIMEOUT, default 15, SHALL set the cycles to wait for tx_busy to rise after a send pulse.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; low clears all state immediately.
REQ-005 rx_data  input  8  received byte from the UART receiver.
REQ-006 rx_ready  input  1  level from the receiver; high while rx_data is valid and unacknowledged.
REQ-007 rx_ack  output  1  one-cycle pulse to the receiver's reset_ready input.
REQ-008 tx_data  output  8  byte presented to the UART transmitter.
REQ-009 tx_send  output  1  one-cycle pulse to the transmitter's send input.
REQ-010 tx_busy  input  1  transmitter busy level.
REQ-011 count  output  log2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
REQ-012 full / empty  output  1 each  count==DEPTH / count==0.
REQ-013 overflow  output  1  sticky flag: a byte was dropped because the FIFO was full.

Function
REQ-014 Capture FSM states SHALL be C_IDLE and C_WAIT_LOW.
REQ-015 In C_IDLE with rx_ready=1, the block SHALL push rx_data if not full, pulse rx_ack for exactly one cycle, and go to C_WAIT_LOW.
REQ-016 C_WAIT_LOW SHALL return to C_IDLE only when rx_ready=0, so one held ready level causes exactly one push.
REQ-017 In C_IDLE with rx_ready=1 and full=1, the byte SHALL be discarded, rx_ack still pulsed, and overflow set.
REQ-018 full SHALL be evaluated from the registered count; a push while full is dropped even if a pop occurs in the same cycle.
REQ-019 Transmit FSM states SHALL be T_IDLE, T_SEND, T_WAIT_BUSY and T_WAIT_DONE.
REQ-020 In T_IDLE with empty=0 and tx_busy=0, the block SHALL pop the head byte into the tx_data register and go to T_SEND.
REQ-021 T_SEND SHALL assert tx_send for one cycle (one cycle after the pop) and go to T_WAIT_BUSY.
REQ-022 T_WAIT_BUSY SHALL go to T_WAIT_DONE when tx_busy=1, or to T_IDLE after BUSY_TIMEOUT cycles without tx_busy=1.
REQ-023 T_WAIT_DONE SHALL go to T_IDLE when tx_busy=0.
REQ-024 tx_data SHALL hold its value from the pop until the next pop.
REQ-025 A simultaneous push and pop SHALL leave count unchanged and preserve byte order.
REQ-026 Read and write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; count SHALL never exceed DEPTH or underflow.
REQ-027 Bytes SHALL leave in arrival order (FIFO).
REQ-028 Minimum latency from an rx_ready rise (empty FIFO, idle transmitter) to tx_send SHALL be 3 cycles: push at edge 1, pop at edge 2, send at edge 3.

Reset
REQ-029 While reset=0, outputs SHALL be: rx_ack=0, tx_send=0, tx_data=8'h00, count=0, empty=1, full=0, overflow=0; both FSMs SHALL be in their idle states and both pointers 0.
REQ-030 overflow SHALL be cleared only by reset.
REQ-031 Reset asserted mid-transfer SHALL discard FIFO contents; after release, the block SHALL wait for a new rx_ready rise and SHALL NOT re-send.
REQ-032 FIFO storage contents need not be reset.

Structure
REQ-033 FSM state encodings and the default DEPTH/BUSY_TIMEOUT values SHALL live in the shared uart package/include alongside the baud constants.
REQ-034 FIFO storage and pointers SHALL be a sub-module named byte_fifo (push, pop, din, dout, count, full, empty).
REQ-035 The bridge SHALL sit between uart_receive (ready/reset_ready) and uart_transmitter (send/busy) in the PC-to-PC top level.

Verification
REQ-036 Single byte: reset, then rx_data=8'hA5 with rx_ready held 10 cycles -> one rx_ack pulse, tx_send 3 cycles after rx_ready rise with tx_data=8'hA5, count back to 0.
REQ-037 Order: push 8'h01, 8'h02, 8'h03 with tx_busy held 1 -> count=3; release busy -> three tx_send pulses carrying 01, 02, 03 in order.
REQ-038 Overflow, DEPTH=8: tx_busy held 1, push 9 bytes (00..08) -> full=1 after the 8th, 9 rx_ack pulses, overflow=1; drain yields 00..07 only.
REQ-039 Simultaneous push/pop at count=4 -> count stays 4; output order intact.
REQ-040 Timeout: tx_busy tied 0 -> after tx_send, FSM returns to T_IDLE in BUSY_TIMEOUT+1 cycles and sends the next byte.
REQ-041 Reset mid-operation: assert reset with count=5 and FSM in T_WAIT_DONE -> all REQ-029 values take effect without a clock edge; no tx_send after release.

Source files
------------

// File: rtl/uart_byte_bridge_pkg.sv
// Shared UART constants: baud timing, bridge defaults and the bridge FSM encodings.
package uart_byte_bridge_pkg;

    localparam int CLK_HZ   = 50_000_000;
    localparam int BAUD     = 115_200;
    localparam int BAUD_DIV = CLK_HZ / BAUD;

    localparam int BYTE_W           = 8;
    localparam int DEF_DEPTH        = 8;
    localparam int DEF_BUSY_TIMEOUT = 15;

    typedef enum logic {
        C_IDLE,
        C_WAIT_LOW
    } cap_state_t;

    typedef enum logic [1:0] {
        T_IDLE,
        T_SEND,
        T_WAIT_BUSY,
        T_WAIT_DONE
    } tx_state_t;

endpackage

// File: rtl/uart_byte_bridge_fifo.sv
// Byte FIFO for the bridge: power-of-2 depth, wrapping pointers, registered occupancy count.
module byte_fifo
    import uart_byte_bridge_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [BYTE_W-1:0] din,
    output logic [BYTE_W-1:0] dout,
    output logic [$clog2(DEPTH):0] count,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    // Full/empty come from the registered count, so a push while full is
    // dropped even when a pop happens on the same edge.
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_byte_bridge.sv
// Buffers bytes from a UART receiver and forwards them, in order, to a UART transmitter.
module uart_byte_bridge
    import uart_byte_bridge_pkg::*;
#(
    parameter int DEPTH        = DEF_DEPTH,
    parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [BYTE_W-1:0]      rx_data,
    input  logic                   rx_ready,
    output logic                   rx_ack,
    output logic [BYTE_W-1:0]      tx_data,
    output logic                   tx_send,
    input  logic                   tx_busy,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow,
    output logic                   cap_state,
    output logic [1:0]             tx_state
);

    localparam int TMO_W = $clog2(BUSY_TIMEOUT + 2);

    // Handshakes: the receiver holds rx_ready high while rx_data is valid; we
    // take it once per high level and answer with a one-cycle rx_ack. Toward
    // the transmitter, tx_send pulses once while tx_busy is low, then we wait
    // for busy to rise (bounded by BUSY_TIMEOUT) and fall before the next byte.
    cap_state_t        cap_q;
    tx_state_t         tx_q;
    logic [TMO_W-1:0]  tmo_q;
    logic [BYTE_W-1:0] fifo_dout;
    logic              push;
    logic              pop;

    assign push      = (cap_q == C_IDLE) && rx_ready && !full;
    assign pop       = (tx_q == T_IDLE) && !empty && !tx_busy;
    assign cap_state = cap_q;
    assign tx_state  = tx_q;

    byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (rx_data),
        .dout  (fifo_dout),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_q    <= C_IDLE;
            rx_ack   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            rx_ack <= 1'b0;
            case (cap_q)
                C_IDLE: begin
                    if (rx_ready) begin
                        rx_ack <= 1'b1;
                        cap_q  <= C_WAIT_LOW;
                        if (full) overflow <= 1'b1;
                    end
                end
                C_WAIT_LOW: begin
                    if (!rx_ready) cap_q <= C_IDLE;
                end
                default: cap_q <= C_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_q    <= T_IDLE;
            tx_send <= 1'b0;
            tx_data <= '0;
            tmo_q   <= '0;
        end else begin
            tx_send <= 1'b0;
            case (tx_q)
                T_IDLE: begin
                    if (pop) begin
                        tx_data <= fifo_dout;
                        tx_q    <= T_SEND;
                    end
                end
                T_SEND: begin
                    tx_send <= 1'b1;
                    tmo_q   <= '0;
                    tx_q    <= T_WAIT_BUSY;
                end
                T_WAIT_BUSY: begin
                    // A transmitter that never raises busy must not stall the bridge.
                    if (tx_busy) begin
                        tx_q <= T_WAIT_DONE;
                    end else if (tmo_q == TMO_W'(BUSY_TIMEOUT)) begin
                        tx_q <= T_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                T_WAIT_DONE: begin
                    if (!tx_busy) tx_q <= T_IDLE;
                end
                default: tx_q <= T_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_byte_bridge.sv
// Scoreboard bench for uart_byte_bridge: bytes queued on drive, checked on each tx_send.
module tb_uart_byte_bridge;

    localparam int DEPTH = 8;
    localparam int BT    = 15;

    logic       clk;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_ack;
    logic [7:0] tx_data;
    logic       tx_send;
    logic       tx_busy;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       cap_state;
    logic [1:0] tx_state;

    logic       busy_force;
    logic       busy_model;
    logic       model_en;
    int         busy_cnt;

    logic [7:0] exp_q[$];
    int         checks;
    int         errors;
    int         ack_cnt;
    int         send_cnt;

    assign tx_busy = busy_force | busy_model;

    uart_byte_bridge #(.DEPTH(DEPTH), .BUSY_TIMEOUT(BT)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .rx_ack    (rx_ack),
        .tx_data   (tx_data),
        .tx_send   (tx_send),
        .tx_busy   (tx_busy),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .cap_state (cap_state),
        .tx_state  (tx_state)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Transmitter model: busy for a few cycles after each send when enabled.
    always @(negedge clk) begin
        if (!reset) begin
            busy_cnt = 0;
        end else if (tx_send && model_en) begin
            busy_cnt = 4;
        end else if (busy_cnt > 0) begin
            busy_cnt = busy_cnt - 1;
        end
        busy_model = (busy_cnt > 0);
    end

    // Output monitor / scoreboard
    always @(negedge clk) begin
        if (reset) begin
            if (rx_ack) ack_cnt++;
            if (tx_send) begin
                send_cnt++;
                if (exp_q.size() > 0) check("tx_data", tx_data, exp_q.pop_front());
                else check("tx_unexpected", 1, 0);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold, input bit kept);
        rx_data  = b;
        rx_ready = 1'b1;
        if (kept) exp_q.push_back(b);
        tick(hold);
        rx_ready = 1'b0;
        tick(1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || tx_state != 2'd0 || !empty) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("drain_bound", 32'(n < 400), 1);
    endtask

    initial begin
        int a0;
        int s0;
        int lat;
        int n;
        int t;
        checks     = 0;
        errors     = 0;
        ack_cnt    = 0;
        send_cnt   = 0;
        busy_force = 1'b0;
        busy_model = 1'b0;
        model_en   = 1'b0;
        busy_cnt   = 0;
        rx_data    = 8'h00;
        rx_ready   = 1'b0;
        reset      = 1'b0;

        // Reset state
        tick(3);
        check("rst_rx_ack", rx_ack, 0);
        check("rst_tx_send", tx_send, 0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_overflow", overflow, 0);
        check("rst_cap_state", cap_state, 0);
        check("rst_tx_state", tx_state, 0);
        reset = 1'b1;
        tick(2);

        // Single byte, latency 3 from rx_ready rise
        a0 = ack_cnt;
        lat = 0;
        rx_data  = 8'hA5;
        rx_ready = 1'b1;
        exp_q.push_back(8'hA5);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (tx_send && lat == 0) lat = i;
        end
        rx_ready = 1'b0;
        tick(1);
        check("single_latency", lat, 3);
        check("single_acks", ack_cnt - a0, 1);
        wait_drain();
        check("single_count", count, 0);

        // Order with busy held, then released
        model_en   = 1'b1;
        busy_force = 1'b1;
        s0 = send_cnt;
        send_byte(8'h01, 3, 1);
        send_byte(8'h02, 3, 1);
        send_byte(8'h03, 3, 1);
        check("order_count", count, 3);
        check("order_no_send", send_cnt - s0, 0);
        busy_force = 1'b0;
        wait_drain();
        check("order_sends", send_cnt - s0, 3);

        // Overflow: 9 bytes into a depth-8 FIFO
        busy_force = 1'b1;
        a0 = ack_cnt;
        for (int i = 0; i < 9; i++) begin
            send_byte(8'(i), 2, i < DEPTH);
            if (i == DEPTH - 1) begin
                check("ovf_full", full, 1);
                check("ovf_count8", count, DEPTH);
                check("ovf_not_yet", overflow, 0);
            end
        end
        check("ovf_acks", ack_cnt - a0, 9);
        check("ovf_flag", overflow, 1);
        check("ovf_count_after", count, DEPTH);
        busy_force = 1'b0;
        wait_drain();
        check("ovf_sticky", overflow, 1);
        check("ovf_empty", empty, 1);

        // Simultaneous push and pop at count 4
        busy_force = 1'b1;
        for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i), 2, 1);
        check("sim_count_pre", count, 4);
        rx_data  = 8'h55;
        rx_ready = 1'b1;
        exp_q.push_back(8'h55);
        busy_force = 1'b0;
        tick(1);
        check("sim_count_same", count, 4);
        check("sim_tx_state", tx_state, 1);
        rx_ready = 1'b0;
        tick(1);
        wait_drain();

        // Busy timeout with tx_busy held low
        model_en   = 1'b0;
        busy_force = 1'b1;
        send_byte(8'hC1, 2, 1);
        send_byte(8'hC2, 2, 1);
        busy_force = 1'b0;
        n = 0;
        while (!tx_send && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("tmo_first_send", tx_send, 1);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (tx_state != 2'd0 && t < 100);
        check("tmo_back_idle", t, BT + 1);
        do begin
            @(negedge clk);
            t++;
        end while (!tx_send && t < 100);
        check("tmo_next_send", t, BT + 3);
        wait_drain();
        check("queue_left", exp_q.size(), 0);

        // Reset mid-operation: count 5, transmitter in T_WAIT_DONE
        model_en   = 1'b1;
        busy_force = 1'b1;
        for (int i = 0; i < 6; i++) send_byte(8'h60 + 8'(i), 2, 1);
        busy_force = 1'b0;
        n = 0;
        while (tx_state != 2'd3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("mid_wait_done", tx_state, 3);
        check("mid_count5", count, 5);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rx_ack", rx_ack, 0);
        check("mid_tx_send", tx_send, 0);
        check("mid_tx_data", tx_data, 8'h00);
        check("mid_count", count, 0);
        check("mid_empty", empty, 1);
        check("mid_full", full, 0);
        check("mid_overflow", overflow, 0);
        check("mid_tx_state", tx_state, 0);
        check("mid_cap_state", cap_state, 0);
        exp_q.delete();
        tick(2);
        reset = 1'b1;
        s0 = send_cnt;
        tick(40);
        check("post_no_send", send_cnt - s0, 0);
        check("post_count", count, 0);
        check("post_tx_state", tx_state, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
